// File: rtl/divider_pkg.sv
// Shared register offsets and default divide latency for the divider CPU window.
package divider_pkg;

  localparam logic [2:0] OFS_DVSRH  = 3'd0;
  localparam logic [2:0] OFS_DVSRL  = 3'd1;
  localparam logic [2:0] OFS_DVDDH  = 3'd2;
  localparam logic [2:0] OFS_DVDDL  = 3'd3;
  localparam logic [2:0] OFS_REH    = 3'd4;
  localparam logic [2:0] OFS_REL    = 3'd5;
  localparam logic [2:0] OFS_STATUS = 3'd6;

  localparam int DIV_CYCLES_DEF = 34;

endpackage

// File: rtl/divider_cpu_if_if.sv
// CPU-side bus of the divider register window.
interface divider_cpu_if_if;

  logic       cpu_sel;
  logic       cpu_rw;
  logic [2:0] cpu_addr;
  logic [7:0] cpu_data_in;
  logic [7:0] cpu_data_out;

  modport master (
    output cpu_sel, cpu_rw, cpu_addr, cpu_data_in,
    input  cpu_data_out
  );

  modport slave (
    input  cpu_sel, cpu_rw, cpu_addr, cpu_data_in,
    output cpu_data_out
  );

endinterface

// File: rtl/cpu_access_strobe.sv
// Rising-edge detector on a CPU access qualifier; fire is high for the one
// cycle in which the qualifier is first sampled high.
module cpu_access_strobe (
  input  logic clk_6,
  input  logic reset_n,
  input  logic qual,
  output logic fire
);

  logic qual_q;

  always_ff @(posedge clk_6 or negedge reset_n) begin
    if (!reset_n) qual_q <= 1'b0;
    else          qual_q <= qual;
  end

  assign fire = qual & ~qual_q;

endmodule

// File: rtl/divider_cpu_if.sv
// CPU register window in front of the divider: write strobes, result readback
// with a low-byte shadow, and a busy timer started by the DVSRL write.
module divider_cpu_if
  import divider_pkg::*;
#(
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic             clk_6,
  input  logic             reset_n,
  divider_cpu_if_if.slave  cpu,
  input  logic [7:0]       REH_DATA_IN,
  input  logic [7:0]       REL_DATA_IN,
  output logic             DVSRH_WR,
  output logic             DVSRL_WR,
  output logic             DVDDH_WR,
  output logic             DVDDL_WR,
  output logic [7:0]       wr_data,
  output logic             busy
);

  localparam int CW = $clog2(DIV_CYCLES + 1);

  logic          wr_qual, rd_qual;
  logic          wr_fire, rd_fire;
  logic [7:0]    rd_data;
  logic [7:0]    rel_shadow;
  logic          shadow_valid;
  logic [CW-1:0] div_cnt;

  assign wr_qual = cpu.cpu_sel & ~cpu.cpu_rw;
  assign rd_qual = cpu.cpu_sel &  cpu.cpu_rw;

  cpu_access_strobe u_wr_edge (
    .clk_6   (clk_6),
    .reset_n (reset_n),
    .qual    (wr_qual),
    .fire    (wr_fire)
  );

  cpu_access_strobe u_rd_edge (
    .clk_6   (clk_6),
    .reset_n (reset_n),
    .qual    (rd_qual),
    .fire    (rd_fire)
  );

  // Offsets 4-7 fire the edge detector but decode to no strobe.
  always_ff @(posedge clk_6 or negedge reset_n) begin
    if (!reset_n) begin
      DVSRH_WR <= 1'b0;
      DVSRL_WR <= 1'b0;
      DVDDH_WR <= 1'b0;
      DVDDL_WR <= 1'b0;
      wr_data  <= 8'h00;
    end else begin
      DVSRH_WR <= wr_fire && (cpu.cpu_addr == OFS_DVSRH);
      DVSRL_WR <= wr_fire && (cpu.cpu_addr == OFS_DVSRL);
      DVDDH_WR <= wr_fire && (cpu.cpu_addr == OFS_DVDDH);
      DVDDL_WR <= wr_fire && (cpu.cpu_addr == OFS_DVDDL);
      if (wr_fire) wr_data <= cpu.cpu_data_in;
    end
  end

  always_ff @(posedge clk_6 or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else if (DVSRL_WR) begin
      div_cnt <= CW'(DIV_CYCLES);
    end else if (div_cnt != '0) begin
      div_cnt <= div_cnt - CW'(1);
    end
  end

  assign busy = (div_cnt != '0);

  always_comb begin
    rd_data = 8'h00;
    case (cpu.cpu_addr)
      OFS_REH:    rd_data = REH_DATA_IN;
      OFS_REL:    rd_data = shadow_valid ? rel_shadow : REL_DATA_IN;
      OFS_STATUS: rd_data = {busy, shadow_valid, 6'b0};
      default:    rd_data = 8'h00;
    endcase
  end

  // Reading REH freezes REL so a 16-bit read is coherent; a new divide
  // start makes the frozen byte stale, so it wins over a same-cycle read.
  always_ff @(posedge clk_6 or negedge reset_n) begin
    if (!reset_n) begin
      cpu.cpu_data_out <= 8'h00;
      rel_shadow       <= 8'h00;
      shadow_valid     <= 1'b0;
    end else begin
      if (rd_fire) begin
        cpu.cpu_data_out <= rd_data;
        if (cpu.cpu_addr == OFS_REH) begin
          rel_shadow   <= REL_DATA_IN;
          shadow_valid <= 1'b1;
        end else if (cpu.cpu_addr == OFS_REL) begin
          shadow_valid <= 1'b0;
        end
      end
      if (DVSRL_WR) shadow_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_divider_cpu_if.sv
// Self-checking bench for divider_cpu_if: read results go through a queue
// scoreboard, strobes and busy timing are checked directly.
module tb_divider_cpu_if;
  import divider_pkg::*;

  logic       clk_6;
  logic       reset_n;
  logic [7:0] reh, rel;
  logic       dvsrh_wr, dvsrl_wr, dvddh_wr, dvddl_wr;
  logic [7:0] wr_data;
  logic       busy;
  logic [3:0] strb;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];

  divider_cpu_if_if bus ();

  divider_cpu_if #(.DIV_CYCLES(34)) dut (
    .clk_6       (clk_6),
    .reset_n     (reset_n),
    .cpu         (bus),
    .REH_DATA_IN (reh),
    .REL_DATA_IN (rel),
    .DVSRH_WR    (dvsrh_wr),
    .DVSRL_WR    (dvsrl_wr),
    .DVDDH_WR    (dvddh_wr),
    .DVDDL_WR    (dvddl_wr),
    .wr_data     (wr_data),
    .busy        (busy)
  );

  assign strb = {dvddl_wr, dvddh_wr, dvsrl_wr, dvsrh_wr};

  initial clk_6 = 1'b0;
  always #5 clk_6 = ~clk_6;

  task automatic chk_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Read data is due one cycle after the read qualifier first rises.
  logic rd_prev, rd_due;
  always @(posedge clk_6 or negedge reset_n) begin
    if (!reset_n) begin
      rd_prev <= 1'b0;
      rd_due  <= 1'b0;
    end else begin
      rd_due  <= (bus.cpu_sel & bus.cpu_rw) & ~rd_prev;
      rd_prev <= bus.cpu_sel & bus.cpu_rw;
    end
  end

  always @(negedge clk_6) begin
    if (rd_due) begin
      if (exp_q.size() == 0) chk_val("rd_unexpected", 32'd1, 32'd0);
      else                   chk_val("rd_data", bus.cpu_data_out, exp_q.pop_front());
    end
  end

  task automatic cpu_write(input logic [2:0] a, input logic [7:0] d, input int hold);
    int hits;
    logic [3:0] exp_vec;
    exp_vec = (a < 3'd4) ? 4'(1 << a) : 4'b0;
    hits = 0;
    @(negedge clk_6);
    bus.cpu_sel = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = a; bus.cpu_data_in = d;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk_6);
      if (strb != 4'b0) begin
        hits++;
        chk_val("wr_strobe_sel", strb, exp_vec);
        chk_val("wr_data", wr_data, d);
      end
    end
    bus.cpu_sel = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_data_in = 8'h00;
    chk_val("wr_strobe_count", hits, (a < 3'd4) ? 1 : 0);
  endtask

  task automatic cpu_read(input logic [2:0] a, input logic [7:0] exp);
    @(negedge clk_6);
    bus.cpu_sel = 1'b1; bus.cpu_rw = 1'b1; bus.cpu_addr = a;
    exp_q.push_back(exp);
    @(negedge clk_6);
    bus.cpu_sel = 1'b0;
    @(negedge clk_6);
    chk_val("rd_hold", bus.cpu_data_out, exp);
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_6);
      if (!busy) break;
      n++;
    end
  endtask

  initial begin
    int n;
    reset_n = 1'b0;
    bus.cpu_sel = 1'b0; bus.cpu_rw = 1'b1; bus.cpu_addr = 3'd0; bus.cpu_data_in = 8'h00;
    reh = 8'h00; rel = 8'h00;
    repeat (3) @(negedge clk_6);
    chk_val("rst_strobes", strb, 4'b0);
    chk_val("rst_wr_data", wr_data, 8'h00);
    chk_val("rst_busy", busy, 1'b0);
    chk_val("rst_rd_data", bus.cpu_data_out, 8'h00);
    reset_n = 1'b1;

    // long write, one strobe, data held afterwards
    cpu_write(OFS_DVSRH, 8'h12, 5);
    repeat (3) @(negedge clk_6);
    chk_val("wr_data_hold", wr_data, 8'h12);
    chk_val("busy_after_dvsrh", busy, 1'b0);
    cpu_write(OFS_DVDDH, 8'h21, 2);
    cpu_write(OFS_DVDDL, 8'h43, 3);
    chk_val("busy_after_dvdd", busy, 1'b0);

    // divide start
    cpu_write(OFS_DVSRL, 8'h07, 1);
    count_busy(n);
    chk_val("busy_len", n, 34);
    cpu_read(OFS_STATUS, 8'h00);

    // restart while busy
    cpu_write(OFS_DVSRL, 8'h08, 1);
    repeat (5) @(negedge clk_6);
    cpu_read(OFS_STATUS, 8'h80);
    repeat (2) @(negedge clk_6);
    chk_val("busy_mid", busy, 1'b1);
    cpu_write(OFS_DVSRL, 8'h09, 1);
    chk_val("busy_at_restart", busy, 1'b1);
    count_busy(n);
    chk_val("busy_restart_len", n, 34);

    // coherent result readback
    reh = 8'hAB; rel = 8'hCD;
    cpu_read(OFS_REH, 8'hAB);
    cpu_read(OFS_STATUS, 8'h40);
    rel = 8'h00;
    cpu_read(OFS_REL, 8'hCD);
    cpu_read(OFS_REL, 8'h00);
    cpu_read(OFS_STATUS, 8'h00);

    // divide start invalidates the shadow
    rel = 8'h11;
    cpu_read(OFS_REH, 8'hAB);
    rel = 8'h5A;
    cpu_write(OFS_DVSRL, 8'h01, 1);
    cpu_read(OFS_STATUS, 8'h80);
    cpu_read(OFS_REL, 8'h5A);
    count_busy(n);

    // read-only / reserved offsets
    cpu_write(OFS_REL, 8'hEE, 3);
    cpu_write(3'd7, 8'hEF, 2);
    cpu_read(OFS_DVDDH, 8'h00);
    cpu_read(3'd7, 8'h00);
    cpu_read(OFS_DVSRH, 8'h00);

    // address change mid-access gives no second strobe
    @(negedge clk_6);
    bus.cpu_sel = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = OFS_DVDDH; bus.cpu_data_in = 8'h33;
    @(negedge clk_6);
    chk_val("addr_chg_first", strb, 4'b0100);
    bus.cpu_addr = OFS_DVDDL;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_6);
      if (strb != 4'b0) n++;
    end
    chk_val("addr_chg_extra", n, 0);
    bus.cpu_sel = 1'b0; bus.cpu_rw = 1'b1;

    // reset mid-busy with a write access in flight
    cpu_write(OFS_DVSRL, 8'h02, 1);
    repeat (5) @(negedge clk_6);
    cpu_read(OFS_STATUS, 8'h80);
    @(negedge clk_6);
    bus.cpu_sel = 1'b1; bus.cpu_rw = 1'b0; bus.cpu_addr = OFS_DVSRH; bus.cpu_data_in = 8'h5C;
    reset_n = 1'b0;
    #1;
    chk_val("rst_mid_busy", busy, 1'b0);
    chk_val("rst_mid_rd_data", bus.cpu_data_out, 8'h00);
    chk_val("rst_mid_wr_data", wr_data, 8'h00);
    chk_val("rst_mid_strobes", strb, 4'b0);
    n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_6);
      if (strb != 4'b0) n++;
    end
    chk_val("rst_hold_strobes", n, 0);
    reset_n = 1'b1;
    @(negedge clk_6);
    chk_val("rst_release_strobe", strb, 4'b0001);
    chk_val("rst_release_wr_data", wr_data, 8'h5C);
    @(negedge clk_6);
    chk_val("rst_release_single", strb, 4'b0);
    bus.cpu_sel = 1'b0; bus.cpu_rw = 1'b1;
    repeat (2) @(negedge clk_6);

    chk_val("sb_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
